// File: rtl/program_loader.sv
// Debug-side loader: assembles big-endian received bytes into instruction words and
// writes them to consecutive fetch-memory addresses until HALT or the memory is full.
module program_loader #(
  parameter int                 NB_INST   = 32,
  parameter int                 NB_ADDR   = 10,
  parameter int                 MEM_DEPTH = 1024,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFC000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_debug_unit,
  output logic               o_mem_wen,
  output logic               o_mem_ren,
  output logic [NB_INST-1:0] o_mem_data,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic               o_done,
  output logic               o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

  state_t             state_q,   state_d;
  logic [1:0]         cnt_q,     cnt_d;
  logic [NB_INST-1:0] shift_q,   shift_d;
  logic [NB_INST-1:0] data_q,    data_d;
  logic [NB_ADDR-1:0] addr_q,    addr_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;

    if (i_start) begin
      // Start wins over any byte in the same cycle and discards a partial word.
      state_d = S_RECV;
      addr_d  = '0;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        S_RECV: begin
          if (i_rx_valid) begin
            shift_d = {shift_q[NB_INST-9:0], i_rx_data};
            if (cnt_q == 2'd3) begin
              data_d    = {shift_q[NB_INST-9:0], i_rx_data};
              wr_addr_d = addr_q;
              cnt_d     = '0;
              state_d   = S_WRITE;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          // A byte landing during the write becomes the MSB of the next word.
          if (i_rx_valid) begin
            shift_d = {{(NB_INST-8){1'b0}}, i_rx_data};
            cnt_d   = 2'd1;
          end
          if (data_q == HALT_WORD) begin
            state_d = S_DONE;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_RECV;
            addr_d  = addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_debug_unit = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_mem_ren    = ~o_debug_unit;
  assign o_mem_wen    = (state_q == S_WRITE);
  assign o_mem_data   = data_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_done       = (state_q == S_DONE);
  assign o_overflow   = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (16-word and 4-word memory) share stimulus;
// observed writes are compared with a byte-stream model of the load.
module tb_program_loader;

  localparam logic [31:0] HALT = 32'hFC000000;

  typedef logic [63:0] wr_t;   // {address, data}
  typedef wr_t wr_q_t[$];

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;

  logic        dbg_m, wen_m, ren_m, done_m, ovf_m;
  logic [31:0] data_m;
  logic [3:0]  addr_m;
  logic        dbg_s, wen_s, ren_s, done_s, ovf_s;
  logic [31:0] data_s;
  logic [1:0]  addr_s;

  int total = 0;
  int bad = 0;

  logic [7:0] stim_q[$];
  wr_t        mon_m[$];
  wr_t        mon_s[$];

  always #5 i_clk = ~i_clk;

  program_loader #(.NB_INST(32), .NB_ADDR(4), .MEM_DEPTH(16), .HALT_WORD(HALT)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .o_debug_unit(dbg_m), .o_mem_wen(wen_m), .o_mem_ren(ren_m),
    .o_mem_data(data_m), .o_wr_addr(addr_m), .o_done(done_m), .o_overflow(ovf_m));

  program_loader #(.NB_INST(32), .NB_ADDR(2), .MEM_DEPTH(4), .HALT_WORD(HALT)) u_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .o_debug_unit(dbg_s), .o_mem_wen(wen_s), .o_mem_ren(ren_s),
    .o_mem_data(data_s), .o_wr_addr(addr_s), .o_done(done_s), .o_overflow(ovf_s));

  always @(negedge i_clk) begin
    if (wen_m) mon_m.push_back({32'(addr_m), data_m});
    if (wen_s) mon_s.push_back({32'(addr_s), data_s});
  end

  // Expected writes: bytes since the last start form big-endian words at addresses
  // 0,1,2,...; the load stops after HALT or after the last memory word.
  function automatic wr_q_t model(input int depth);
    wr_q_t q;
    logic [31:0] w;
    q = {};
    for (int i = 0; i * 4 + 3 < stim_q.size(); i++) begin
      w = {stim_q[i*4], stim_q[i*4+1], stim_q[i*4+2], stim_q[i*4+3]};
      q.push_back({32'(i), w});
      if (w == HALT || i == depth - 1) break;
    end
    return q;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    stim_q.delete();
    mon_m.delete();
    mon_s.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    stim_q.push_back(b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], max_gap);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) tick();
    i_reset = 1'b0;
    total++;
    if ({dbg_m, wen_m, ren_m, data_m, addr_m, done_m, ovf_m} !== {3'b001, 32'h0, 4'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_main: dbg=%b wen=%b ren=%b data=%h addr=%0d done=%b ovf=%b required 0 0 1 0 0 0 0",
               dbg_m, wen_m, ren_m, data_m, addr_m, done_m, ovf_m);
    end
    total++;
    if ({dbg_s, wen_s, ren_s, data_s, addr_s, done_s, ovf_s} !== {3'b001, 32'h0, 2'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_small: dbg=%b wen=%b ren=%b data=%h addr=%0d done=%b ovf=%b required 0 0 1 0 0 0 0",
               dbg_s, wen_s, ren_s, data_s, addr_s, done_s, ovf_s);
    end
    $display("test_reset: reset values checked");
  endtask

  task automatic test_first_word();
    do_start();
    send_byte(8'h3C, 0);
    total++;
    if (dbg_m !== 1'b1 || ren_m !== 1'b0) begin
      bad++;
      $display("FAIL recv_ctrl: dbg=%b ren=%b required dbg=1 ren=0", dbg_m, ren_m);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    total++;
    if (wen_m !== 1'b0) begin
      bad++;
      $display("FAIL early_wen: wen=%b required 0 before 4th byte", wen_m);
    end
    send_byte(8'h0A, 0);
    total++;
    if (wen_m !== 1'b1 || data_m !== 32'h3C01000A || addr_m !== 4'd0) begin
      bad++;
      $display("FAIL first_word: wen=%b data=%h addr=%0d required wen=1 data=3c01000a addr=0",
               wen_m, data_m, addr_m);
    end
    tick();
    total++;
    if (wen_m !== 1'b0 || data_m !== 32'h3C01000A || dbg_m !== 1'b1) begin
      bad++;
      $display("FAIL wen_pulse: wen=%b data=%h dbg=%b required wen=0 data=3c01000a dbg=1",
               wen_m, data_m, dbg_m);
    end
    $display("test_first_word: word 3c01000a at addr 0");
  endtask

  task automatic test_program(input int n_words, input int max_gap, input string tag);
    wr_q_t exp;
    do_start();
    for (int i = 0; i < n_words - 1; i++) send_word(rand_word(), max_gap);
    send_word(HALT, max_gap);
    repeat (4) tick();
    exp = model(16);
    total++;
    if (mon_m.size() != exp.size()) begin
      bad++;
      $display("FAIL %s_count: writes=%0d required %0d", tag, mon_m.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (mon_m[i] !== exp[i]) begin
          bad++;
          $display("FAIL %s_write%0d: got addr=%0d data=%h required addr=%0d data=%h", tag, i,
                   mon_m[i][63:32], mon_m[i][31:0], exp[i][63:32], exp[i][31:0]);
        end
      end
    end
    total++;
    if (done_m !== 1'b1 || dbg_m !== 1'b0 || ren_m !== 1'b1 || ovf_m !== 1'b0 ||
        addr_m !== 4'(n_words - 1)) begin
      bad++;
      $display("FAIL %s_done: done=%b dbg=%b ren=%b ovf=%b addr=%0d required 1 0 1 0 %0d",
               tag, done_m, dbg_m, ren_m, ovf_m, addr_m, n_words - 1);
    end
    $display("test_program %s: %0d words, max gap %0d", tag, n_words, max_gap);
  endtask

  task automatic test_overflow();
    wr_q_t exp;
    do_start();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 2);
    repeat (4) tick();
    exp = model(4);
    total++;
    if (mon_s.size() != exp.size() || exp.size() != 4) begin
      bad++;
      $display("FAIL ovf_count: writes=%0d required 4", mon_s.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (mon_s[i] !== exp[i]) begin
          bad++;
          $display("FAIL ovf_write%0d: got addr=%0d data=%h required addr=%0d data=%h", i,
                   mon_s[i][63:32], mon_s[i][31:0], exp[i][63:32], exp[i][31:0]);
        end
      end
    end
    total++;
    if (ovf_s !== 1'b1 || done_s !== 1'b0 || dbg_s !== 1'b0 || ren_s !== 1'b1 || wen_s !== 1'b0) begin
      bad++;
      $display("FAIL ovf_flags: ovf=%b done=%b dbg=%b ren=%b wen=%b required 1 0 0 1 0",
               ovf_s, done_s, dbg_s, ren_s, wen_s);
    end
    total++;
    if (mon_m.size() != 5) begin
      bad++;
      $display("FAIL ovf_big_count: writes=%0d required 5", mon_m.size());
    end
    $display("test_overflow: 5 words into 4-word memory");
  endtask

  task automatic test_byte_in_write();
    wr_q_t exp;
    logic [31:0] w0, w1;
    w0 = rand_word();
    w1 = rand_word();
    do_start();
    send_word(w0, 0);
    total++;
    if (wen_m !== 1'b1) begin
      bad++;
      $display("FAIL biw_wen: wen=%b required 1 when next byte is strobed", wen_m);
    end
    send_word(w1, 0);
    send_word(HALT, 0);
    repeat (4) tick();
    exp = model(16);
    total++;
    if (mon_m.size() != 3 || mon_m[1] !== exp[1] || mon_m[2] !== exp[2]) begin
      bad++;
      $display("FAIL byte_in_write: writes=%0d word1=%h required 3 writes, word1 addr=1 data=%h",
               mon_m.size(), (mon_m.size() > 1) ? mon_m[1][31:0] : 32'h0, w1);
    end
    $display("test_byte_in_write: %h then %h", w0, w1);
  endtask

  task automatic test_abort();
    wr_q_t exp;
    do_start();
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 1);
    tick();
    total++;
    if (mon_m.size() != 0) begin
      bad++;
      $display("FAIL abort_partial: writes=%0d required 0", mon_m.size());
    end
    do_start();
    send_word(rand_word(), 1);
    send_word(HALT, 1);
    repeat (4) tick();
    exp = model(16);
    total++;
    if (mon_m.size() != 2 || mon_m[0] !== exp[0] || mon_m[1] !== exp[1]) begin
      bad++;
      $display("FAIL abort_reload: writes=%0d first=%h required 2 writes, first addr=0 data=%h",
               mon_m.size(), (mon_m.size() > 0) ? mon_m[0] : 64'h0, exp[0]);
    end
    $display("test_abort: restart after 2 bytes");
  endtask

  task automatic test_reset_mid();
    do_start();
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    total++;
    if ({dbg_m, wen_m, ren_m, done_m, ovf_m} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_recv: dbg=%b wen=%b ren=%b done=%b ovf=%b required 0 0 1 0 0",
               dbg_m, wen_m, ren_m, done_m, ovf_m);
    end
    mon_m.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    repeat (3) tick();
    total++;
    if (mon_m.size() != 0 || dbg_m !== 1'b0) begin
      bad++;
      $display("FAIL idle_bytes: writes=%0d dbg=%b required 0 writes dbg=0", mon_m.size(), dbg_m);
    end
    do_start();
    send_word(HALT, 0);
    repeat (2) tick();
    total++;
    if (done_m !== 1'b1) begin
      bad++;
      $display("FAIL halt_only: done=%b required 1", done_m);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    total++;
    if ({dbg_m, wen_m, ren_m, data_m, addr_m, done_m, ovf_m} !== {3'b001, 32'h0, 4'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_done: dbg=%b wen=%b ren=%b data=%h addr=%0d done=%b ovf=%b required 0 0 1 0 0 0 0",
               dbg_m, wen_m, ren_m, data_m, addr_m, done_m, ovf_m);
    end
    $display("test_reset_mid: reset in RECV and DONE");
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_program(11, 0, "eleven");
    test_overflow();
    test_byte_in_write();
    test_abort();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_program(int'($urandom_range(12, 1)), 3, "random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
